// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared widths, FSM state encodings and the saturating-add
// helper for the MAC sequencer. The helper is only used when MAC_SAT_EN is
// defined.
package mac_ctrl_pkg;

  localparam int DATA_W = 4;
  localparam int ACC_W  = 12;
  localparam int LEN_W  = 6;

  // Two's-complement limits of the accumulator.
  localparam logic [ACC_W-1:0] ACC_MAX = 12'h7FF;
  localparam logic [ACC_W-1:0] ACC_MIN = 12'h800;

  localparam logic [LEN_W-1:0] LEN_ZERO = 6'd0;
  localparam logic [LEN_W-1:0] LEN_ONE  = 6'd1;

  // FSM state encodings. Plain constants are used so that older tools
  // which reject enum-typed state registers still accept the design.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Result of a clamped addition.
  typedef struct packed {
    logic             clamp;
    logic [ACC_W-1:0] val;
  } acc_sum_t;

  // Signed add that clamps to the accumulator range. Overflow is detected
  // when the carry-out sign bit disagrees with the result sign bit.
  function automatic acc_sum_t sat_add(input logic [ACC_W-1:0] a,
                                       input logic [ACC_W-1:0] b);
    logic [ACC_W:0] wide;
    acc_sum_t       res;
    wide      = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    res.clamp = wide[ACC_W] ^ wide[ACC_W-1];
    if (res.clamp) begin
      if (wide[ACC_W]) begin
        res.val = ACC_MIN;
      end else begin
        res.val = ACC_MAX;
      end
    end else begin
      res.val = wide[ACC_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_acc_unit.sv
// mac_acc_unit: signed DATA_W x DATA_W multiply, sign-extension to ACC_W and
// accumulate with synchronous clear and enable.
// Optional feature macro MAC_SAT_EN: when defined the accumulator saturates
// and ovf is a sticky clamp flag; otherwise the sum wraps and ovf is 0.
module mac_acc_unit
  import mac_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] w_data,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic [ACC_W-1:0]           prod_ext_s;
  logic [ACC_W-1:0]           acc_r;

  // Full-width signed product, sign-extended to the accumulator width.
  always_comb begin
    prod_s     = $signed(in_data) * $signed(w_data);
    prod_ext_s = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
  end

`ifdef MAC_SAT_EN
  acc_sum_t sum_s;
  logic     ovf_r;

  // Clamped sum of the running total and the new product.
  always_comb begin
    sum_s = sat_add(acc_r, prod_ext_s);
  end

  // Accumulator and sticky overflow; later beats continue from the clamp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= 12'd0;
      ovf_r <= 1'b0;
    end else if (clr) begin
      acc_r <= 12'd0;
      ovf_r <= 1'b0;
    end else if (en) begin
      acc_r <= sum_s.val;
      if (sum_s.clamp) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign ovf = ovf_r;
`else
  logic [ACC_W-1:0] sum_s;

  // Wrapping sum modulo 2^ACC_W.
  always_comb begin
    sum_s = acc_r + prod_ext_s;
  end

  // Accumulator register; wrap-around is not reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= 12'd0;
    end else if (clr) begin
      acc_r <= 12'd0;
    end else if (en) begin
      acc_r <= sum_s;
    end
  end

  assign ovf = 1'b0;
`endif

  assign acc = acc_r;

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: vector sequencer around mac_acc_unit. Latches the vector
// length on start, counts accepted operand beats and presents the final dot
// product on a valid/ready result port. Handshake outputs are decoded from
// the state register only, so no input reaches an output combinationally.
// Optional feature macro MAC_SAT_EN (see mac_acc_unit): saturating
// accumulation with sticky ovf.
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] w_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              ovf
);

  state_t           state_r;
  state_t           state_next_s;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] count_r;
  logic             clr_s;
  logic             beat_s;
  logic             last_s;

  // Vector start clears the datapath; beats only happen in RUN.
  always_comb begin
    clr_s  = (state_r == IDLE) && start;
    beat_s = (state_r == RUN) && in_valid;
    last_s = (count_r == (len_r - LEN_ONE));
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len != LEN_ZERO) begin
            state_next_s = RUN;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (beat_s && last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Length latch and beat counter, both restarted by a new vector.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      len_r   <= 6'd0;
      count_r <= 6'd0;
    end else if (clr_s) begin
      len_r   <= len;
      count_r <= 6'd0;
    end else if (beat_s) begin
      count_r <= count_r + LEN_ONE;
    end
  end

  mac_acc_unit u_acc (
    .clk     (clk),
    .rst     (rstb),
    .clr     (clr_s),
    .en      (beat_s),
    .in_data (in_data),
    .w_data  (w_data),
    .acc     (out_data),
    .ovf     (ovf)
  );

  assign busy      = (state_r != IDLE);
  assign in_ready  = (state_r == RUN);
  assign out_valid = (state_r == DONE);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed self-checking bench for mac_seq_ctrl.
// Inputs change on the falling edge; outputs are checked on the falling edge
// before new inputs are applied. Expectations for the long vector follow
// MAC_SAT_EN.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rstb;
  logic        start;
  logic [5:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [3:0]  w_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  mac_seq_ctrl dut (
    .clk       (clk),
    .rstb      (rstb),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] res();
    return 32'($signed(out_data));
  endfunction

  task automatic start_vec(input int l);
    start = 1'b1;
    len   = 6'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input int a, input int b);
    in_valid = 1'b1;
    in_data  = 4'(a);
    w_data   = 4'(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_data  = 4'd7;
    w_data   = 4'd7;
    @(negedge clk);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int exp_long;
    int exp_ovf;
    rstb      = 1'b1;
    start     = 1'b0;
    len       = 6'd0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    w_data    = 4'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", res(), 0);
    rstb = 1'b0;
    @(negedge clk);

    // len=3, back-to-back beats
    start_vec(3);
    check("t1_busy", 32'(busy), 1);
    check("t1_in_ready", 32'(in_ready), 1);
    beat(1, 2);
    beat(2, 4);
    check("t1_not_done", 32'(out_valid), 0);
    beat(3, 6);
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_out_data", res(), 28);
    check("t1_ovf", 32'(ovf), 0);
    check("t1_in_ready_done", 32'(in_ready), 0);
    handshake();
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_valid", 32'(out_valid), 0);

    // len=0: result 0 next cycle, never ready for operands
    check("t2_pre_in_ready", 32'(in_ready), 0);
    start_vec(0);
    check("t2_out_valid", 32'(out_valid), 1);
    check("t2_out_data", res(), 0);
    check("t2_in_ready", 32'(in_ready), 0);
    in_valid = 1'b1;
    handshake();
    in_valid = 1'b0;
    check("t2_idle_busy", 32'(busy), 0);
    check("t2_idle_in_ready", 32'(in_ready), 0);

    // len=3 with gaps in in_valid and a stalled consumer
    start_vec(3);
    idle_cycle();
    beat(1, 2);
    idle_cycle();
    beat(2, 4);
    idle_cycle();
    check("t3_not_done", 32'(out_valid), 0);
    beat(3, 6);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 32'(out_valid), 1);
      check("t3_hold_data", res(), 28);
      check("t3_hold_busy", 32'(busy), 1);
      @(negedge clk);
    end
    handshake();
    check("t3_idle_busy", 32'(busy), 0);

    // len=40 of (-8,-8): 40*64 = 2560
`ifdef MAC_SAT_EN
    exp_long = 2047;
    exp_ovf  = 1;
`else
    exp_long = -1536;
    exp_ovf  = 0;
`endif
    start_vec(40);
    for (int i = 0; i < 40; i++) begin
      beat(-8, -8);
    end
    check("t4_out_valid", 32'(out_valid), 1);
    check("t4_out_data", res(), exp_long);
    check("t4_ovf", 32'(ovf), exp_ovf);
    handshake();

    // asynchronous reset mid-vector, then a fresh len=1 vector
    start_vec(4);
    beat(1, 1);
    beat(2, 2);
    check("t5_pre_rst_busy", 32'(busy), 1);
    #2 rstb = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_in_ready", 32'(in_ready), 0);
    check("t5_rst_out_valid", 32'(out_valid), 0);
    check("t5_rst_out_data", res(), 0);
    check("t5_rst_ovf", 32'(ovf), 0);
    @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    start_vec(1);
    beat(3, -2);
    check("t5_out_valid", 32'(out_valid), 1);
    check("t5_out_data", res(), -6);
    handshake();

    // start held high during RUN and DONE must be ignored
    start = 1'b1;
    len   = 6'd2;
    @(negedge clk);
    len = 6'd5;
    beat(7, 7);
    check("t6_mid_valid", 32'(out_valid), 0);
    beat(-8, 7);
    check("t6_out_valid", 32'(out_valid), 1);
    check("t6_out_data", res(), -7);
    @(negedge clk);
    check("t6_hold_valid", 32'(out_valid), 1);
    check("t6_hold_data", res(), -7);
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    check("t6_idle_valid", 32'(out_valid), 0);
    check("t6_idle_busy", 32'(busy), 0);
    @(negedge clk);
    check("t6_single_busy", 32'(busy), 0);
    check("t6_single_valid", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the signed 4x4 multiply-accumulate datapath: accepts a vector length, streams that many (IN, W) operand pairs through a valid/ready port into an internal MAC, and presents the final 12-bit dot product on a valid/ready result port. Sits between the operand source (buffer/DMA) and the result consumer. It owns accumulator clearing and beat counting, so upstream logic never tracks vector boundaries.

## Interface
- DATA_W, 4, signed operand width (IN and W)
- ACC_W, 12, signed accumulator/result width
- LEN_W, 6, vector-length field width (max length 2^LEN_W-1)

- clk  input  1  clock, rising edge
- rstb  input  1  reset, asynchronous, active-high
- start  input  1  begin a vector; sampled only in IDLE
- len  input  LEN_W  number of pairs in the vector; latched on start
- busy  output  1  high whenever state != IDLE
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller accepts a pair this cycle
- in_data  input  DATA_W  signed IN operand
- w_data  input  DATA_W  signed W operand
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  ACC_W  signed dot-product result
- ovf  output  1  sticky signed-overflow flag for current vector

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=0, out_valid=0. start=1 -> latch len, clear acc, count and ovf; go to RUN if len!=0, else DONE (result 0).
- RUN: in_ready=1. Beat = in_valid & in_ready. Each beat: acc <= acc + sext(in_data*w_data), count++. Beat with count==len-1 -> DONE.
- DONE: out_valid=1, out_data=acc, ovf valid. Hold all until out_valid & out_ready -> IDLE.
- start ignored outside IDLE; in_valid ignored outside RUN. No beat occurs in the DONE->IDLE cycle.
- Arithmetic: product full 2*DATA_W signed (range -56..64), sign-extended to ACC_W before addition.
- Reset (any state, any cycle): state IDLE, acc 0, count 0, ovf 0, busy 0, in_ready 0, out_valid 0, out_data 0. In-flight vector discarded.

## Timing
- in_ready and out_valid are decoded from registered state only; no input-to-output combinational paths.
- Beat accepted on edge t -> accumulated value registered at t; last beat at edge t -> out_valid=1 in cycle t+1.
- len==0: start at edge t -> out_valid=1, out_data=0 in cycle t+1.
- Throughput: one pair per cycle in RUN; a vector of N pairs occupies N+2 cycles minimum (start, N beats, result handshake).
- out_ready held high in DONE: result consumed in first DONE cycle; earliest next start is the following cycle.

## Configuration
- MAC_SAT_EN defined: additions saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1] (-2048..2047); ovf set sticky on any clamped addition; later beats continue from the clamped value.
- MAC_SAT_EN undefined: accumulation wraps modulo 2^ACC_W; ovf tied to 0.

## Structure
- Package mac_ctrl_pkg: state enum (IDLE/RUN/DONE), default DATA_W/ACC_W/LEN_W, ACC_MAX/ACC_MIN constants.
- Sub-module mac_acc_unit: signed multiply, sign-extend, add with clear/enable, optional saturation and overflow detect. Controller holds FSM, length latch, beat counter, handshakes.

## Test plan
- len=3, pairs (1,2),(2,4),(3,6), in_valid always high -> out_valid exactly 1 cycle after 3rd beat, out_data=28, ovf=0.
- len=0 start -> out_valid next cycle, out_data=0; in_ready stays 0 throughout.
- len=3 same pairs, in_valid toggling every other cycle and out_ready low 5 cycles in DONE -> out_data holds 28, busy=1 until handshake, then IDLE.
- len=40, all pairs (-8,-8) -> without MAC_SAT_EN out_data=-1536, ovf=0; with MAC_SAT_EN out_data=2047, ovf=1.
- len=4, assert rstb after 2 beats -> all outputs 0 asynchronously; then len=1, pair (3,-2) -> out_data=-6.
- start pulsed during RUN and DONE of a len=2 vector (pairs (7,7),(-8,7)) -> ignored, out_data=-7, single result produced.
